hazard_tracker: RTL and testbench
=================================

# hazard_tracker

Sequential companion to the EXE-stage forwarding logic in the ARM pipeline. It keeps a shadow pipeline of write-back destinations for the EXE, MEM and WB stages. From that shadow pipeline it drives the MEM/WB destination and enable signals that forwarding consumes. It also raises the ID-stage stall (`hazard_out`) for dependencies forwarding cannot resolve. The block honours the cache freeze and the branch flush, and counts stall cycles for performance debug.

## Interface
- `REG_W`, default 4: register index width (16 architectural registers).
- `CNT_W`, default 16: stall counter width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `use_forwarding_in` in 1: forwarding enabled (static mode bit).
- `freeze_in` in 1: cache/SRAM not ready; hold all state.
- `flush_in` in 1: branch taken; kill the ID instruction entering EXE.
- `id_src1_in`, `id_src2_in` in REG_W: ID-stage source registers.
- `id_has_src1_in`, `id_has_src2_in` in 1: source fields valid.
- `id_dest_in` in REG_W: ID-stage destination.
- `id_wb_en_in` in 1: ID instruction writes a register.
- `id_mem_read_in` in 1: ID instruction is a load.
- `hazard_out` out 1: stall IF/ID and insert a bubble into EXE.
- `exe_dest_out` out REG_W; `exe_wb_en_out` out 1; `exe_mem_read_out` out 1.
- `mem_wb_reg_dest_out` out REG_W; `mem_wb_en_out` out 1.
- `wb_wb_reg_dest_out` out REG_W; `wb_wb_en_out` out 1.
- `stall_cycles_out` out CNT_W: saturating count of stall cycles.

## Operation
- **Slots.** There are three slots: EXE, MEM, WB. Each slot holds {dest, wb_en, mem_read}. A bubble is {0, 0, 0}.
- **Match rule.** `src_match(s)` is (id_srcN == s.dest) & id_has_srcN & s.wb_en, evaluated for N = 1, 2.
- **Hazard, forwarding off.** `hazard_out` = src_match(EXE) | src_match(MEM).
- **Hazard, forwarding on.** `hazard_out` = src_match(EXE) & EXE.mem_read. This is the load-use case only.
- **WB slot never causes a hazard.** The register file writes on the falling edge, so the value is ready for the ID read.
- `hazard_out` is combinational from the ID inputs and slot state. It is not gated by `freeze_in`.
- **Advance when `freeze_in`=0.**
  - WB <= MEM; MEM <= EXE.
  - EXE <= bubble if `hazard_out` or `flush_in`; otherwise EXE <= {id_dest, id_wb_en, id_mem_read}.
- **Freeze.** `freeze_in`=1 holds all slots and the counter. Freeze dominates flush: a flush asserted during freeze is lost. The upstream branch logic keeps flush asserted until freeze drops.
- **Stall counter.** Increments when `hazard_out`=1 and `freeze_in`=0. It saturates at all-ones and does not wrap.
- **Outputs.** All slot outputs are direct register outputs.
- **Register 15.** No special handling for R15/PC; it is tracked like any other register.

## Timing
- **Reset.** All slots are bubbles, so every dest output is 0 and every enable is 0. `stall_cycles_out`=0. `hazard_out`=0 because no slot has wb_en set.
- **Reset mid-operation.** Asynchronous; clears state immediately, independent of freeze.
- **Latency.** An ID instruction appears on `exe_*` one unfrozen edge after issue, on `mem_*` after two, and on `wb_*` after three.
- **Load-use, forwarding on.** Exactly one stall cycle: the load moves to MEM, where forwarding resolves the dependency.
- **Dependency, forwarding off.** Up to two stall cycles, until the producer reaches WB.
- **Simultaneous hazard and flush.** A single bubble is inserted.
- **Simultaneous hazard and freeze.** `hazard_out` stays high and nothing advances.

## Structure
- Shared pipeline package holds:
  - `slot_t` struct {dest, wb_en, mem_read};
  - the `SLOT_BUBBLE` constant;
  - `REG_W`.
- A sub-module `hazard_slot_reg` is natural: one slot register with load, bubble-insert and hold controls. Instantiate it three times.
- The hazard compare stays in the top.

## Test plan
- **Reset and idle.** Assert `rst` mid-cycle with slots loaded -> all outputs 0 immediately; `hazard_out`=0.
- **Load-use, forwarding on.** Forwarding on; issue LDR R3 (wb_en=1, mem_read=1), then ADD with src1=R3 -> `hazard_out`=1 for exactly 1 cycle; EXE holds a bubble; `mem_wb_reg_dest_out`=3 with `mem_wb_en_out`=1; counter=1.
- **Dependency, forwarding off.** Forwarding off; ADD R5, then SUB with src2=R5 -> 2 stall cycles; the SUB enters EXE when R5 reaches WB (`wb_wb_reg_dest_out`=5); counter=2.
- **No false hazard.** Forwarding on; ALU write R4 followed by a read of R4 -> `hazard_out`=0. Also: `id_has_src1_in`=0 with a matching index -> no hazard.
- **Freeze.** Assert `freeze_in` for 5 cycles during a load-use stall -> slots, outputs and counter unchanged; `hazard_out` stays 1; the pipeline resumes correctly after release.
- **Flush and saturation.** Flush with a valid ID write -> `exe_wb_en_out`=0 next edge. Then preload the counter to 0xFFFE and hold a hazard 3 cycles -> counter ends at 0xFFFF.

Source files
------------

// File: rtl/hazard_tracker_pkg.sv
// hazard_tracker_pkg: shared slot types for the ID hazard tracker.
// Holds the shadow-pipeline slot layout and the match helper.
package hazard_tracker_pkg;

  localparam int REG_W = 4;

  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_read;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '{
    dest:     '0,
    wb_en:    1'b0,
    mem_read: 1'b0
  };

  // A source matches a slot only when it is a real read of a real write.
  function automatic logic src_match(
    input logic [REG_W-1:0] src,
    input logic             has_src,
    input slot_t            s
  );
    return has_src && s.wb_en && (src == s.dest);
  endfunction

endpackage

// File: rtl/hazard_slot_reg.sv
// hazard_slot_reg: one shadow-pipeline slot.
// Bubble insertion beats load; neither asserted means hold.
module hazard_slot_reg
  import hazard_tracker_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  bubble,
  input  slot_t d,
  output slot_t q
);

  // Slot state: clear on reset, else bubble, load or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SLOT_BUBBLE;
    end else if (bubble) begin
      q <= SLOT_BUBBLE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// hazard_tracker: shadow EXE/MEM/WB destinations and ID stall.
// Drives forwarding dest/enable and counts stall cycles.
module hazard_tracker #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             use_forwarding_in,
  input  logic             freeze_in,
  input  logic             flush_in,
  input  logic [REG_W-1:0] id_src1_in,
  input  logic [REG_W-1:0] id_src2_in,
  input  logic             id_has_src1_in,
  input  logic             id_has_src2_in,
  input  logic [REG_W-1:0] id_dest_in,
  input  logic             id_wb_en_in,
  input  logic             id_mem_read_in,
  output logic             hazard_out,
  output logic [REG_W-1:0] exe_dest_out,
  output logic             exe_wb_en_out,
  output logic             exe_mem_read_out,
  output logic [REG_W-1:0] mem_wb_reg_dest_out,
  output logic             mem_wb_en_out,
  output logic [REG_W-1:0] wb_wb_reg_dest_out,
  output logic             wb_wb_en_out,
  output logic [CNT_W-1:0] stall_cycles_out
);

  import hazard_tracker_pkg::slot_t;
  import hazard_tracker_pkg::src_match;

  slot_t id_slot;
  slot_t exe_q;
  slot_t mem_q;
  slot_t wb_q;

  logic exe_hit;
  logic mem_hit;
  logic advance;
  logic exe_kill;

  logic [CNT_W-1:0] stall_cnt;
  logic             unused_bits;

  assign id_slot = '{
    dest:     id_dest_in,
    wb_en:    id_wb_en_in,
    mem_read: id_mem_read_in
  };

  // Producer match against EXE and MEM for either source.
  always_comb begin
    exe_hit = src_match(id_src1_in, id_has_src1_in, exe_q)
            | src_match(id_src2_in, id_has_src2_in, exe_q);
    mem_hit = src_match(id_src1_in, id_has_src1_in, mem_q)
            | src_match(id_src2_in, id_has_src2_in, mem_q);
  end

  // With forwarding only load-use stalls; without it any
  // EXE/MEM producer stalls until it reaches WB.
  always_comb begin
    hazard_out = 1'b0;
    unique case (1'b1)
      use_forwarding_in:
        hazard_out = exe_hit & exe_q.mem_read;
      !use_forwarding_in:
        hazard_out = exe_hit | mem_hit;
      default:
        hazard_out = 1'b0;
    endcase
  end

  assign advance  = !freeze_in;
  assign exe_kill = advance & (hazard_out | flush_in);

  hazard_slot_reg u_exe (
    .clk    (clk),
    .rst    (rst),
    .load   (advance),
    .bubble (exe_kill),
    .d      (id_slot),
    .q      (exe_q)
  );

  hazard_slot_reg u_mem (
    .clk    (clk),
    .rst    (rst),
    .load   (advance),
    .bubble (1'b0),
    .d      (exe_q),
    .q      (mem_q)
  );

  hazard_slot_reg u_wb (
    .clk    (clk),
    .rst    (rst),
    .load   (advance),
    .bubble (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  // Saturating count of unfrozen stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (advance && hazard_out && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign exe_dest_out        = exe_q.dest;
  assign exe_wb_en_out       = exe_q.wb_en;
  assign exe_mem_read_out    = exe_q.mem_read;
  assign mem_wb_reg_dest_out = mem_q.dest;
  assign mem_wb_en_out       = mem_q.wb_en;
  assign wb_wb_reg_dest_out  = wb_q.dest;
  assign wb_wb_en_out        = wb_q.wb_en;
  assign stall_cycles_out    = stall_cnt;

  assign unused_bits = ^{mem_q.mem_read, wb_q.mem_read};

endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: directed checks of the hazard tracker.
// A second instance with a 2-bit counter exercises saturation.
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fwd = 1'b0;
  logic       freeze = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] src1 = '0;
  logic [3:0] src2 = '0;
  logic       has1 = 1'b0;
  logic       has2 = 1'b0;
  logic [3:0] dest = '0;
  logic       wb = 1'b0;
  logic       mr = 1'b0;

  logic        hazard;
  logic [3:0]  exe_dest;
  logic        exe_wb;
  logic        exe_mr;
  logic [3:0]  mem_dest;
  logic        mem_wb;
  logic [3:0]  wb_dest;
  logic        wb_wb;
  logic [15:0] cnt;

  logic        s_hazard;
  logic [3:0]  s_exe_dest;
  logic        s_exe_wb;
  logic        s_exe_mr;
  logic [3:0]  s_mem_dest;
  logic        s_mem_wb;
  logic [3:0]  s_wb_dest;
  logic        s_wb_wb;
  logic [1:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_tracker dut (
    .clk                 (clk),
    .rst                 (rst),
    .use_forwarding_in   (fwd),
    .freeze_in           (freeze),
    .flush_in            (flush),
    .id_src1_in          (src1),
    .id_src2_in          (src2),
    .id_has_src1_in      (has1),
    .id_has_src2_in      (has2),
    .id_dest_in          (dest),
    .id_wb_en_in         (wb),
    .id_mem_read_in      (mr),
    .hazard_out          (hazard),
    .exe_dest_out        (exe_dest),
    .exe_wb_en_out       (exe_wb),
    .exe_mem_read_out    (exe_mr),
    .mem_wb_reg_dest_out (mem_dest),
    .mem_wb_en_out       (mem_wb),
    .wb_wb_reg_dest_out  (wb_dest),
    .wb_wb_en_out        (wb_wb),
    .stall_cycles_out    (cnt)
  );

  hazard_tracker #(.CNT_W(2)) u_sat (
    .clk                 (clk),
    .rst                 (rst),
    .use_forwarding_in   (fwd),
    .freeze_in           (freeze),
    .flush_in            (flush),
    .id_src1_in          (src1),
    .id_src2_in          (src2),
    .id_has_src1_in      (has1),
    .id_has_src2_in      (has2),
    .id_dest_in          (dest),
    .id_wb_en_in         (wb),
    .id_mem_read_in      (mr),
    .hazard_out          (s_hazard),
    .exe_dest_out        (s_exe_dest),
    .exe_wb_en_out       (s_exe_wb),
    .exe_mem_read_out    (s_exe_mr),
    .mem_wb_reg_dest_out (s_mem_dest),
    .mem_wb_en_out       (s_mem_wb),
    .wb_wb_reg_dest_out  (s_wb_dest),
    .wb_wb_en_out        (s_wb_wb),
    .stall_cycles_out    (s_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(
    input logic [3:0] a, input logic ha,
    input logic [3:0] b, input logic hb,
    input logic [3:0] d, input logic w, input logic m
  );
    src1 = a; has1 = ha;
    src2 = b; has2 = hb;
    dest = d; wb = w; mr = m;
    #1;
  endtask

  task automatic idle();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    freeze = 1'b0;
    flush  = 1'b0;
    idle();
    @(posedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({exe_dest, exe_wb, exe_mr, mem_dest, mem_wb,
         wb_dest, wb_wb, cnt, hazard} !== '0) begin
      errors++;
      $display("FAIL reset_init: got %h expected 0",
        {exe_dest, exe_wb, exe_mr, mem_dest, mem_wb,
         wb_dest, wb_wb, cnt, hazard});
    end
    rst = 1'b0;
    fwd = 1'b1;
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
    step();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0);
    step();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1);
    step();
    checks++;
    if ({exe_dest, mem_dest, wb_dest} !== {4'd9, 4'd8, 4'd7}) begin
      errors++;
      $display("FAIL latency: got %h expected 987",
        {exe_dest, mem_dest, wb_dest});
    end
    set_id(4'd9, 1'b1, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
    checks++;
    if (hazard !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_hazard: got %b expected 1", hazard);
    end
    freeze = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({exe_dest, exe_wb, exe_mr, mem_dest, mem_wb,
         wb_dest, wb_wb, cnt, hazard} !== '0) begin
      errors++;
      $display("FAIL reset_async: got %h expected 0",
        {exe_dest, exe_wb, exe_mr, mem_dest, mem_wb,
         wb_dest, wb_wb, cnt, hazard});
    end
    rst = 1'b0;
    freeze = 1'b0;
    idle();
  endtask

  task automatic test_load_use();
    fwd = 1'b1;
    pulse_reset();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1);
    step();
    set_id(4'd3, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
    checks++;
    if (hazard !== 1'b1) begin
      errors++;
      $display("FAIL lu_hazard: got %b expected 1", hazard);
    end
    step();
    checks++;
    if ({hazard, exe_wb, exe_dest, mem_dest, mem_wb, cnt}
        !== {1'b0, 1'b0, 4'd0, 4'd3, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL lu_stall: got h=%b ew=%b ed=%0d md=%0d mw=%b c=%0d expected 0 0 0 3 1 1",
        hazard, exe_wb, exe_dest, mem_dest, mem_wb, cnt);
    end
    step();
    checks++;
    if ({exe_dest, exe_wb, cnt} !== {4'd6, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL lu_issue: got ed=%0d ew=%b c=%0d expected 6 1 1",
        exe_dest, exe_wb, cnt);
    end
    idle();
  endtask

  task automatic test_dep_nofwd();
    fwd = 1'b0;
    pulse_reset();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
    step();
    set_id(4'd0, 1'b0, 4'd5, 1'b1, 4'd2, 1'b1, 1'b0);
    checks++;
    if (hazard !== 1'b1) begin
      errors++;
      $display("FAIL dep_exe: got %b expected 1", hazard);
    end
    step();
    checks++;
    if ({hazard, exe_wb, mem_dest} !== {1'b1, 1'b0, 4'd5}) begin
      errors++;
      $display("FAIL dep_mem: got h=%b ew=%b md=%0d expected 1 0 5",
        hazard, exe_wb, mem_dest);
    end
    step();
    checks++;
    if ({hazard, wb_dest, wb_wb, cnt}
        !== {1'b0, 4'd5, 1'b1, 16'd2}) begin
      errors++;
      $display("FAIL dep_wb: got h=%b wd=%0d ww=%b c=%0d expected 0 5 1 2",
        hazard, wb_dest, wb_wb, cnt);
    end
    step();
    checks++;
    if ({exe_dest, exe_wb, cnt} !== {4'd2, 1'b1, 16'd2}) begin
      errors++;
      $display("FAIL dep_issue: got ed=%0d ew=%b c=%0d expected 2 1 2",
        exe_dest, exe_wb, cnt);
    end
    idle();
  endtask

  task automatic test_no_false_hazard();
    fwd = 1'b1;
    pulse_reset();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
    step();
    set_id(4'd4, 1'b1, 4'd4, 1'b1, 4'd1, 1'b1, 1'b0);
    checks++;
    if (hazard !== 1'b0) begin
      errors++;
      $display("FAIL nf_alu_fwd: got %b expected 0", hazard);
    end
    fwd = 1'b0;
    set_id(4'd4, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
    checks++;
    if (hazard !== 1'b0) begin
      errors++;
      $display("FAIL nf_has_src: got %b expected 0", hazard);
    end
    set_id(4'd4, 1'b1, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
    checks++;
    if (hazard !== 1'b1) begin
      errors++;
      $display("FAIL nf_control: got %b expected 1", hazard);
    end
    set_id(4'd15, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0);
    checks++;
    if (hazard !== 1'b0) begin
      errors++;
      $display("FAIL nf_other_reg: got %b expected 0", hazard);
    end
    idle();
  endtask

  task automatic test_freeze();
    fwd = 1'b1;
    pulse_reset();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1);
    step();
    set_id(4'd0, 1'b0, 4'd3, 1'b1, 4'd6, 1'b1, 1'b0);
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({hazard, exe_dest, exe_wb, exe_mr, mem_wb, wb_wb, cnt}
          !== {1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0}) begin
        errors++;
        $display("FAIL frz_hold[%0d]: got h=%b ed=%0d ew=%b em=%b mw=%b ww=%b c=%0d expected 1 3 1 1 0 0 0",
          i, hazard, exe_dest, exe_wb, exe_mr, mem_wb, wb_wb, cnt);
      end
    end
    freeze = 1'b0;
    step();
    checks++;
    if ({hazard, exe_wb, mem_dest, mem_wb, cnt}
        !== {1'b0, 1'b0, 4'd3, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL frz_release: got h=%b ew=%b md=%0d mw=%b c=%0d expected 0 0 3 1 1",
        hazard, exe_wb, mem_dest, mem_wb, cnt);
    end
    step();
    checks++;
    if ({exe_dest, exe_wb, wb_dest, wb_wb} !== {4'd6, 1'b1, 4'd3, 1'b1}) begin
      errors++;
      $display("FAIL frz_resume: got ed=%0d ew=%b wd=%0d ww=%b expected 6 1 3 1",
        exe_dest, exe_wb, wb_dest, wb_wb);
    end
    idle();
  endtask

  task automatic test_flush();
    fwd = 1'b1;
    pulse_reset();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    checks++;
    if ({exe_dest, exe_wb} !== {4'd0, 1'b0}) begin
      errors++;
      $display("FAIL flush_kill: got ed=%0d ew=%b expected 0 0",
        exe_dest, exe_wb);
    end
    flush = 1'b0;
    step();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0);
    freeze = 1'b1;
    flush  = 1'b1;
    step();
    checks++;
    if ({exe_dest, exe_wb, mem_wb} !== {4'd9, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL flush_frozen: got ed=%0d ew=%b mw=%b expected 9 1 0",
        exe_dest, exe_wb, mem_wb);
    end
    freeze = 1'b0;
    step();
    checks++;
    if ({exe_wb, mem_dest, mem_wb} !== {1'b0, 4'd9, 1'b1}) begin
      errors++;
      $display("FAIL flush_after_frz: got ew=%b md=%0d mw=%b expected 0 9 1",
        exe_wb, mem_dest, mem_wb);
    end
    flush = 1'b0;
    idle();
  endtask

  task automatic test_saturation();
    fwd = 1'b0;
    pulse_reset();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
    step();
    set_id(4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
    step();
    step();
    step();
    checks++;
    if ({cnt, s_cnt} !== {16'd2, 2'd2}) begin
      errors++;
      $display("FAIL sat_preload: got c=%0d s=%0d expected 2 2",
        cnt, s_cnt);
    end
    set_id(4'd6, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
    step();
    step();
    step();
    set_id(4'd7, 1'b1, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0);
    step();
    checks++;
    if ({cnt, s_cnt} !== {16'd5, 2'd3}) begin
      errors++;
      $display("FAIL sat_hold: got c=%0d s=%0d expected 5 3",
        cnt, s_cnt);
    end
    idle();
  endtask

  initial begin
    #1;
    test_reset();
    test_load_use();
    test_dep_nofwd();
    test_no_false_hazard();
    test_freeze();
    test_flush();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
